legv8_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the LEGv8 datapath. It sequences one shared memory port, the register file, the ALU and the sign extender through fetch, decode, execute, memory and write-back steps. It also supplies the immediate-format select that the sign extender and ALU-source mux consume. It sits between the instruction register and the datapath strobes, replacing the single-cycle combinational control.

---
 rtl/legv8_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/exec/mem/write-back over one shared memory port.
// Define LEGV8_CTRL_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
module legv8_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_isel,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write,
   output logic        reg2loc,
   output logic        alu_src,
   output logic [3:0]  alu_op,
   output logic        mem_to_reg,
   output logic [1:0]  ext_sel,
   output logic        illegal
`ifdef LEGV8_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      C_ILL, C_B, C_CBZ, C_LDUR, C_STUR, C_ADD, C_SUB, C_AND, C_ORR
   } class_t;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   // fetch_en, br_en and cbz_en are the state-derived halves of the strobes
   // that must also see mem_ready / zero in the same cycle.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_isel;
      logic       fetch_en;
      logic       pc_src;
      logic       br_en;
      logic       cbz_en;
      logic       reg_write;
      logic       reg2loc;
      logic       alu_src;
      logic [3:0] alu_op;
      logic       mem_to_reg;
      logic [1:0] ext_sel;
      logic       illegal;
   } ctrl_t;

   state_t        state_reg, state_next;
   class_t        class_reg, class_next;
   ctrl_t         ctrl_reg, ctrl_next;
   logic [TW-1:0] tmo_reg, tmo_next;
   logic [10:0]   opcode_reg;
   logic          waiting;
   logic          unused_instr_bits;

   assign unused_instr_bits = ^instr[20:0];

   function automatic class_t decode_op(input logic [10:0] op);
      class_t c;
      c = C_ILL;
      if (op[10:5] == 6'b000101)       c = C_B;
      else if (op[10:3] == 8'hB4)      c = C_CBZ;
      else begin
         case (op)
            11'h7C2: c = C_LDUR;
            11'h7C0: c = C_STUR;
            11'h458: c = C_ADD;
            11'h658: c = C_SUB;
            11'h450: c = C_AND;
            11'h550: c = C_ORR;
            default: c = C_ILL;
         endcase
      end
      return c;
   endfunction

   function automatic ctrl_t ctrl_for(input state_t s, input class_t c);
      ctrl_t o;
      o = '0;
      case (s)
         S_FETCH: begin
            o.mem_req  = 1'b1;
            o.mem_isel = 1'b1;
            o.fetch_en = 1'b1;
         end
         S_EXEC: begin
            case (c)
               C_ADD: o.alu_op = ALU_ADD;
               C_SUB: o.alu_op = ALU_SUB;
               C_AND: o.alu_op = ALU_AND;
               C_ORR: o.alu_op = ALU_ORR;
               C_LDUR, C_STUR: begin
                  o.alu_op  = ALU_ADD;
                  o.alu_src = 1'b1;
                  o.ext_sel = 2'b11;
               end
               C_CBZ: begin
                  o.alu_op  = ALU_PASSB;
                  o.reg2loc = 1'b1;
                  o.ext_sel = 2'b10;
                  o.pc_src  = 1'b1;
                  o.cbz_en  = 1'b1;
               end
               C_B: begin
                  o.ext_sel = 2'b01;
                  o.pc_src  = 1'b1;
                  o.br_en   = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            o.mem_req = 1'b1;
            o.mem_we  = (c == C_STUR);
         end
         S_WB: begin
            o.reg_write  = 1'b1;
            o.mem_to_reg = (c == C_LDUR);
         end
         S_TRAP: o.illegal = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

   assign waiting = ctrl_reg.mem_req & ~mem_ready;

   always_comb begin
      state_next = state_reg;
      class_next = class_reg;
      tmo_next   = '0;
      case (state_reg)
         S_RST:    state_next = S_FETCH;
         S_FETCH:  if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            class_next = decode_op(opcode_reg);
            state_next = (class_next == C_ILL) ? S_TRAP : S_EXEC;
         end
         S_EXEC: begin
            case (class_reg)
               C_LDUR, C_STUR: state_next = S_MEM;
               C_CBZ, C_B:     state_next = S_FETCH;
               default:        state_next = S_WB;
            endcase
         end
         S_MEM:    if (mem_ready) state_next = (class_reg == C_LDUR) ? S_WB : S_FETCH;
         S_WB:     state_next = S_FETCH;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_RST;
      endcase
      // A completing access never reaches this branch, so completion beats the timeout.
      if (waiting) begin
         if (tmo_reg == TMO_LAST) state_next = S_TRAP;
         else                     tmo_next = tmo_reg + 1'b1;
      end
      ctrl_next = ctrl_for(state_next, class_next);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_RST;
         class_reg  <= C_ILL;
         ctrl_reg   <= '0;
         tmo_reg    <= '0;
         opcode_reg <= '0;
      end else begin
         state_reg <= state_next;
         class_reg <= class_next;
         ctrl_reg  <= ctrl_next;
         tmo_reg   <= tmo_next;
         if (ir_write) opcode_reg <= instr[31:21];
      end
   end

   assign mem_req    = ctrl_reg.mem_req;
   assign mem_we     = ctrl_reg.mem_we;
   assign mem_isel   = ctrl_reg.mem_isel;
   assign ir_write   = ctrl_reg.fetch_en & mem_ready;
   assign pc_write   = (ctrl_reg.fetch_en & mem_ready) | ctrl_reg.br_en | (ctrl_reg.cbz_en & zero);
   assign pc_src     = ctrl_reg.pc_src;
   assign reg_write  = ctrl_reg.reg_write;
   assign reg2loc    = ctrl_reg.reg2loc;
   assign alu_src    = ctrl_reg.alu_src;
   assign alu_op     = ctrl_reg.alu_op;
   assign mem_to_reg = ctrl_reg.mem_to_reg;
   assign ext_sel    = ctrl_reg.ext_sel;
   assign illegal    = ctrl_reg.illegal;

`ifdef LEGV8_CTRL_PERF_EN
   logic [31:0] cycle_cnt_reg, instr_cnt_reg;
   logic        retire;

   assign retire = (state_next == S_FETCH) &&
                   (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_reg <= '0;
         instr_cnt_reg <= '0;
      end else if (state_reg != S_TRAP) begin
         cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
         if (retire) instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_reg;
   assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl (MEM_TIMEOUT=4); expected values are hand-derived cycle by cycle.
module tb_legv8_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, mem_isel, ir_write, pc_write, pc_src;
   logic        reg_write, reg2loc, alu_src, mem_to_reg, illegal;
   logic [3:0]  alu_op;
   logic [1:0]  ext_sel;
`ifdef LEGV8_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif
   logic [16:0] all_out;
   int          errors = 0;
   int          checks = 0;

   localparam logic [31:0] I_ADD  = 32'h8B020020;
   localparam logic [31:0] I_SUB  = 32'hCB020020;
   localparam logic [31:0] I_AND  = 32'h8A020020;
   localparam logic [31:0] I_ORR  = 32'hAA020020;
   localparam logic [31:0] I_LDUR = 32'hF8408041;
   localparam logic [31:0] I_STUR = 32'hF8000041;
   localparam logic [31:0] I_CBZ  = 32'hB4000040;
   localparam logic [31:0] I_B    = 32'h14000003;
   localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

   always #5 clk = ~clk;

   legv8_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_isel(mem_isel), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg2loc(reg2loc),
      .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .ext_sel(ext_sel),
      .illegal(illegal)
`ifdef LEGV8_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   assign all_out = {mem_req, mem_we, mem_isel, ir_write, pc_write, pc_src, reg_write,
                     reg2loc, alu_src, alu_op, mem_to_reg, ext_sel, illegal};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts in a FETCH cycle; fetches with zero wait, checks DECODE, returns in the cycle after DECODE.
   task automatic fetch(input string tag, input logic [31:0] ins);
      $display("instr %s %h", tag, ins);
      instr = ins;
      mem_ready = 1'b1;
      #1;
      chk({tag, ".fetch"}, 32'({mem_req, mem_isel, ir_write, pc_write, pc_src}), 32'b11110);
      tick();
      chk({tag, ".decode"}, 32'({mem_req, reg_write, pc_write, illegal}), 32'b0);
      tick();
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("reset_outputs", 32'(all_out), 32'h0);
      tick();

      // ADD: FETCH c1, DECODE c2, EXEC c3, WB c4, next FETCH c5
      fetch("add", I_ADD);
      chk("add.exec", 32'({alu_op, alu_src, reg_write}), 32'b0010_0_0);
      tick();
      chk("add.wb", 32'({reg_write, mem_to_reg, mem_req}), 32'b100);
      tick();
      chk("add.next_fetch", 32'({mem_req, mem_isel}), 32'b11);
`ifdef LEGV8_CTRL_PERF_EN
      chk("perf.cycle_after_add", cycle_cnt, 32'd5);
      chk("perf.instr_after_add", instr_cnt, 32'd1);
`endif

      fetch("sub", I_SUB);
      chk("sub.exec", 32'({alu_op, alu_src}), 32'b0110_0);
      tick();
      chk("sub.wb", 32'(reg_write), 32'd1);
      tick();
      fetch("and", I_AND);
      chk("and.exec", 32'({alu_op, alu_src}), 32'b0000_0);
      tick();
      chk("and.wb", 32'(reg_write), 32'd1);
      tick();
      fetch("orr", I_ORR);
      chk("orr.exec", 32'({alu_op, alu_src}), 32'b0001_0);
      tick();
      chk("orr.wb", 32'(reg_write), 32'd1);
      tick();

      // LDUR with two wait cycles in MEM: 7 cycles total
      fetch("ldur", I_LDUR);
      chk("ldur.exec", 32'({alu_op, alu_src, ext_sel}), 32'b0010_1_11);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("ldur.mem_wait1", 32'({mem_req, mem_isel, mem_we, ir_write}), 32'b1000);
      tick();
      chk("ldur.mem_wait2", 32'({mem_req, mem_isel, mem_we, ir_write}), 32'b1000);
      tick();
      mem_ready = 1'b1;
      #1;
      chk("ldur.mem_done", 32'({mem_req, mem_isel, mem_we}), 32'b100);
      tick();
      chk("ldur.wb", 32'({reg_write, mem_to_reg, mem_req}), 32'b110);
      tick();
      chk("ldur.next_fetch", 32'({mem_req, mem_isel}), 32'b11);

      fetch("stur", I_STUR);
      chk("stur.exec", 32'({alu_op, alu_src, ext_sel}), 32'b0010_1_11);
      tick();
      chk("stur.mem", 32'({mem_req, mem_isel, mem_we}), 32'b101);
      tick();
      chk("stur.next_fetch", 32'({mem_req, mem_isel, reg_write}), 32'b110);

      fetch("cbz_taken", I_CBZ);
      zero = 1'b1;
      #1;
      chk("cbz_taken.exec", 32'({pc_write, pc_src, ext_sel, reg2loc, alu_op}), 32'b1_1_10_1_0111);
      tick();
      zero = 1'b0;
      chk("cbz_taken.next_fetch", 32'(mem_req), 32'd1);
      fetch("cbz_not_taken", I_CBZ);
      chk("cbz_not_taken.exec", 32'({pc_write, ext_sel}), 32'b0_10);
      tick();
      fetch("b", I_B);
      chk("b.exec", 32'({pc_write, pc_src, ext_sel}), 32'b1_1_01);
      tick();
      chk("b.next_fetch", 32'({mem_req, mem_isel}), 32'b11);

      // FETCH ready on the 4th request cycle: completion beats the timeout
      $display("instr fetch_ready_on_4th %h", I_STUR);
      instr = I_STUR;
      mem_ready = 1'b0;
      #1;
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("late_fetch.wait%0d", i), 32'({mem_req, ir_write, illegal}), 32'b100);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      chk("late_fetch.accept", 32'({mem_req, ir_write, illegal}), 32'b110);
      tick();
      chk("late_fetch.decode", 32'({mem_req, illegal}), 32'b00);
      tick();
      tick();
      mem_ready = 1'b0;
      #1;
      chk("stur_reset.mem", 32'({mem_req, mem_we}), 32'b11);
      reset = 1'b1;
      tick();
      chk("stur_reset.outputs", 32'(all_out), 32'h0);
`ifdef LEGV8_CTRL_PERF_EN
      chk("stur_reset.cycle_cnt", cycle_cnt, 32'd0);
      chk("stur_reset.instr_cnt", instr_cnt, 32'd0);
`endif
      reset = 1'b0;
      tick();

      // Illegal opcode: TRAP from the cycle after DECODE, sticky until reset
      fetch("illegal", I_ILL);
      chk("illegal.trap", 32'({illegal, mem_req}), 32'b10);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("illegal.hold%0d", i), 32'({illegal, mem_req, pc_write}), 32'b100);
      end
`ifdef LEGV8_CTRL_PERF_EN
      chk("illegal.cycle_frozen", cycle_cnt, 32'd3);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("illegal.reset_clears", 32'(all_out), 32'h0);
      tick();

      // FETCH never answered: TRAP after 4 request cycles
      $display("instr fetch_timeout");
      mem_ready = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("fetch_timeout.req%0d", i), 32'({mem_req, mem_isel, illegal}), 32'b110);
         tick();
      end
      chk("fetch_timeout.trap", 32'({mem_req, illegal}), 32'b01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      // MEM never answered on STUR: TRAP after 4 request cycles
      fetch("mem_timeout", I_STUR);
      tick();
      mem_ready = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("mem_timeout.req%0d", i), 32'({mem_req, mem_we, illegal}), 32'b110);
         tick();
      end
      chk("mem_timeout.trap", 32'({mem_req, mem_we, illegal}), 32'b001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
